// File: rtl/cpu.sv
// Single-cycle RV32I core. Fetch, decode, execute, memory and writeback are all
// combinational within one cycle; the PC and register file commit on the rising clock edge.
module cpu (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic [31:0] daddr,
  input  logic [31:0] drdata,
  output logic [31:0] dwdata,
  output logic [3:0]  we_dmem,
  output logic [31:0] x31,
  output logic [31:0] PC
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  logic [31:0] pc_q;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode = idata[6:0];
  assign rd     = idata[11:7];
  assign funct3 = idata[14:12];
  assign rs1    = idata[19:15];
  assign rs2    = idata[24:20];
  assign funct7 = idata[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{idata[31]}}, idata[31:20]};
  assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
  assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
  assign imm_u = {idata[31:12], 12'h000};
  assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

  logic        rf_we;
  logic        use_imm;
  logic        a_is_pc;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm_sel;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Any encoding not decoded below leaves every enable low, so it retires as a NOP.
  always_comb begin
    rf_we     = 1'b0;
    use_imm   = 1'b0;
    a_is_pc   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    imm_sel   = imm_i;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    case (opcode)
      OP_LUI: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        imm_sel = imm_u;
        alu_op  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        rf_we   = 1'b1;
        use_imm = 1'b1;
        imm_sel = imm_u;
        a_is_pc = 1'b1;
      end
      OP_JAL: begin
        rf_we  = 1'b1;
        is_jal = 1'b1;
        wb_sel = WB_PC4;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we   = 1'b1;
          is_jalr = 1'b1;
          use_imm = 1'b1;
          wb_sel  = WB_PC4;
        end
      end
      OP_BRANCH: begin
        is_branch = (funct3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
          rf_we   = 1'b1;
          is_load = 1'b1;
          use_imm = 1'b1;
          wb_sel  = WB_MEM;
        end
      end
      OP_STORE: begin
        if (!funct3[2] && funct3 != 3'b011) begin
          is_store = 1'b1;
          use_imm  = 1'b1;
          imm_sel  = imm_s;
        end
      end
      OP_IMM: begin
        if (!((funct3 == 3'b001 && funct7 != 7'b0000000) ||
              (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))) begin
          rf_we   = 1'b1;
          use_imm = 1'b1;
          alu_op  = alu_from_f3(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          rf_we  = 1'b1;
          alu_op = alu_from_f3(funct3, funct7[5]);
        end
      end
      default: ;
    endcase
  end

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_y;

  assign alu_a = a_is_pc ? pc_q : rs1_val;
  assign alu_b = use_imm ? imm_sel : rs2_val;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_y = 32'h0;
    case (alu_op)
      ALU_ADD:    alu_y = alu_a + alu_b;
      ALU_SUB:    alu_y = alu_a - alu_b;
      ALU_SLL:    alu_y = alu_a << shamt;
      ALU_SLT:    alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_y = {31'h0, alu_a < alu_b};
      ALU_XOR:    alu_y = alu_a ^ alu_b;
      ALU_SRL:    alu_y = alu_a >> shamt;
      ALU_SRA:    alu_y = 32'($signed(alu_a) >>> shamt);
      ALU_OR:     alu_y = alu_a | alu_b;
      ALU_AND:    alu_y = alu_a & alu_b;
      ALU_PASS_B: alu_y = alu_b;
      default:    alu_y = 32'h0;
    endcase
  end

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal) begin
      next_pc = pc_q + imm_j;
    end else if (is_jalr) begin
      next_pc = {alu_y[31:1], 1'b0};
    end else if (is_branch && br_taken) begin
      next_pc = pc_q + imm_b;
    end
  end

  // Memory always sees the aligned word; sub-word lanes are picked by the low address bits.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (alu_y[1:0])
      2'b00:   ld_byte = drdata[7:0];
      2'b01:   ld_byte = drdata[15:8];
      2'b10:   ld_byte = drdata[23:16];
      default: ld_byte = drdata[31:24];
    endcase
    ld_half = alu_y[1] ? drdata[31:16] : drdata[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = drdata;
    endcase
  end

  logic [3:0] store_we;

  always_comb begin
    store_we = 4'b0000;
    dwdata   = rs2_val;
    if (is_store) begin
      case (funct3)
        3'b000: begin
          store_we = 4'b0001 << alu_y[1:0];
          dwdata   = {4{rs2_val[7:0]}};
        end
        3'b001: begin
          store_we = 4'b0011 << {alu_y[1], 1'b0};
          dwdata   = {2{rs2_val[15:0]}};
        end
        default: begin
          store_we = 4'hF;
          dwdata   = rs2_val;
        end
      endcase
    end
  end

  logic [31:0] wb_data;

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = ld_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'h0;
      end
    end else begin
      pc_q <= next_pc;
      if (rf_we && rd != 5'd0) begin
        rf[rd] <= wb_data;
      end
    end
  end

  // Write enables are gated by reset so a store word on idata cannot reach memory.
  assign we_dmem = reset ? store_we : 4'b0000;
  assign daddr   = alu_y;
  assign iaddr   = pc_q;
  assign PC      = pc_q;
  assign x31     = rf[31];

endmodule

// File: tb/tb_cpu.sv
// Bench for the single-cycle RV32I core: directed scenarios plus random instruction
// streams checked against an instruction-level reference model of the architecture.
module tb_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic [31:0] daddr;
  logic [31:0] drdata;
  logic [31:0] dwdata;
  logic [3:0]  we_dmem;
  logic [31:0] x31;
  logic [31:0] PC;

  cpu dut (
    .clk     (clk),
    .reset   (reset),
    .iaddr   (iaddr),
    .idata   (idata),
    .daddr   (daddr),
    .drdata  (drdata),
    .dwdata  (dwdata),
    .we_dmem (we_dmem),
    .x31     (x31),
    .PC      (PC)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- data memory served to the DUT ----------------
  logic [31:0] dut_mem [64];

  assign drdata = dut_mem[daddr[7:2]];

  always @(posedge clk) begin
    if (we_dmem[0]) dut_mem[daddr[7:2]][7:0]   <= dwdata[7:0];
    if (we_dmem[1]) dut_mem[daddr[7:2]][15:8]  <= dwdata[15:8];
    if (we_dmem[2]) dut_mem[daddr[7:2]][23:16] <= dwdata[23:16];
    if (we_dmem[3]) dut_mem[daddr[7:2]][31:24] <= dwdata[31:24];
  end

  // ---------------- reference model state ----------------
  typedef enum int {
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_OR, K_AND, K_SRL, K_SRA,
    K_RAW
  } kind_t;

  logic [31:0] ref_pc;
  logic [31:0] ref_x [32];
  logic [7:0]  ref_mem [256];
  logic [3:0]  last_we;

  int n_checks;
  int n_pass;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoder ----------------
  function automatic logic [2:0] f3_of(input kind_t k);
    case (k)
      K_BNE, K_LH, K_SH, K_SLLI, K_SLL:       return 3'b001;
      K_LW, K_SW, K_SLTI, K_SLT:              return 3'b010;
      K_SLTIU, K_SLTU:                        return 3'b011;
      K_BLT, K_LBU, K_XORI, K_XOR:            return 3'b100;
      K_BGE, K_LHU, K_SRLI, K_SRAI, K_SRL, K_SRA: return 3'b101;
      K_BLTU, K_ORI, K_OR:                    return 3'b110;
      K_BGEU, K_ANDI, K_AND:                  return 3'b111;
      default:                                return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] enc(input kind_t k, input int rd, input int rs1,
                                      input int rs2, input logic [31:0] imm);
    logic [4:0] d;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = 5'(rd);
    a  = 5'(rs1);
    b  = 5'(rs2);
    f3 = f3_of(k);
    f7 = (k == K_SUB || k == K_SRA || k == K_SRAI) ? 7'b0100000 : 7'b0000000;
    if (k == K_LUI)   return {imm[31:12], d, 7'b0110111};
    if (k == K_AUIPC) return {imm[31:12], d, 7'b0010111};
    if (k == K_JAL)   return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
    if (k == K_JALR)  return {imm[11:0], a, 3'b000, d, 7'b1100111};
    if (k inside {[K_BEQ:K_BGEU]})
      return {imm[12], imm[10:5], b, a, f3, imm[4:1], imm[11], 7'b1100011};
    if (k inside {[K_LB:K_LHU]})   return {imm[11:0], a, f3, d, 7'b0000011};
    if (k inside {[K_SB:K_SW]})    return {imm[11:5], b, a, f3, imm[4:0], 7'b0100011};
    if (k inside {[K_SLLI:K_SRAI]}) return {f7, imm[4:0], a, f3, d, 7'b0010011};
    if (k inside {[K_ADDI:K_ANDI]}) return {imm[11:0], a, f3, d, 7'b0010011};
    if (k inside {[K_ADD:K_SRA]})  return {f7, b, a, f3, d, 7'b0110011};
    return imm;
  endfunction

  // ---------------- reference model (architectural semantics) ----------------
  function automatic void wr(input int rd, input logic [31:0] v);
    if (rd != 0) ref_x[rd] = v;
  endfunction

  task automatic model_exec(input kind_t k, input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm, output logic [3:0] e_we,
                            output logic [31:0] e_dw, output logic [31:0] e_da,
                            output bit e_mem);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] npc;
    logic [31:0] addr;
    logic [7:0]  ba;
    logic [7:0]  v8;
    logic [15:0] v16;
    a     = ref_x[rs1];
    b     = ref_x[rs2];
    npc   = ref_pc + 32'd4;
    addr  = a + imm;
    ba    = addr[7:0];
    e_we  = 4'b0000;
    e_dw  = 32'h0;
    e_da  = addr;
    e_mem = (k inside {[K_LB:K_SW]});
    case (k)
      K_LUI:   wr(rd, imm & 32'hFFFFF000);
      K_AUIPC: wr(rd, ref_pc + imm);
      K_JAL:   begin wr(rd, ref_pc + 32'd4); npc = ref_pc + imm; end
      K_JALR:  begin npc = addr & ~32'd1; wr(rd, ref_pc + 32'd4); end
      K_BEQ:   if (a == b) npc = ref_pc + imm;
      K_BNE:   if (a != b) npc = ref_pc + imm;
      K_BLT:   if ($signed(a) < $signed(b)) npc = ref_pc + imm;
      K_BGE:   if ($signed(a) >= $signed(b)) npc = ref_pc + imm;
      K_BLTU:  if (a < b) npc = ref_pc + imm;
      K_BGEU:  if (a >= b) npc = ref_pc + imm;
      K_LB:    begin v8 = ref_mem[ba]; wr(rd, {{24{v8[7]}}, v8}); end
      K_LBU:   begin v8 = ref_mem[ba]; wr(rd, {24'h0, v8}); end
      K_LH, K_LHU: begin
        ba  = ba & 8'hFE;
        v16 = {ref_mem[ba + 8'd1], ref_mem[ba]};
        wr(rd, (k == K_LH) ? {{16{v16[15]}}, v16} : {16'h0, v16});
      end
      K_LW: begin
        ba = ba & 8'hFC;
        wr(rd, {ref_mem[ba + 8'd3], ref_mem[ba + 8'd2], ref_mem[ba + 8'd1], ref_mem[ba]});
      end
      K_SB: begin
        ref_mem[ba] = b[7:0];
        e_we = 4'(1 << (addr % 4));
        e_dw = {4{b[7:0]}};
      end
      K_SH: begin
        e_we = ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
        ba   = ba & 8'hFE;
        ref_mem[ba]        = b[7:0];
        ref_mem[ba + 8'd1] = b[15:8];
        e_dw = {2{b[15:0]}};
      end
      K_SW: begin
        ba = ba & 8'hFC;
        for (int i = 0; i < 4; i++) ref_mem[ba + 8'(i)] = b[8*i +: 8];
        e_we = 4'hF;
        e_dw = b;
      end
      K_ADDI:  wr(rd, a + imm);
      K_SLTI:  wr(rd, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
      K_SLTIU: wr(rd, (a < imm) ? 32'd1 : 32'd0);
      K_XORI:  wr(rd, a ^ imm);
      K_ORI:   wr(rd, a | imm);
      K_ANDI:  wr(rd, a & imm);
      K_SLLI:  wr(rd, a << imm[4:0]);
      K_SRLI:  wr(rd, a >> imm[4:0]);
      K_SRAI:  wr(rd, 32'($signed(a) >>> imm[4:0]));
      K_ADD:   wr(rd, a + b);
      K_SUB:   wr(rd, a - b);
      K_SLL:   wr(rd, a << b[4:0]);
      K_SLT:   wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
      K_SLTU:  wr(rd, (a < b) ? 32'd1 : 32'd0);
      K_XOR:   wr(rd, a ^ b);
      K_OR:    wr(rd, a | b);
      K_AND:   wr(rd, a & b);
      K_SRL:   wr(rd, a >> b[4:0]);
      K_SRA:   wr(rd, 32'($signed(a) >>> b[4:0]));
      default: ;
    endcase
    ref_pc = npc;
  endtask

  function automatic void model_reset();
    ref_pc = 32'h0;
    for (int i = 0; i < 32; i++) ref_x[i] = 32'h0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: present the word, check combinational outputs,
  // then let the rising edge retire it and check architectural state.
  task automatic exec_now(input kind_t k, input int rd, input int rs1, input int rs2,
                          input logic [31:0] imm);
    logic [3:0]  e_we;
    logic [31:0] e_dw;
    logic [31:0] e_da;
    bit          e_mem;
    idata = enc(k, rd, rs1, rs2, imm);
    check("iaddr", iaddr, ref_pc);
    model_exec(k, rd, rs1, rs2, imm, e_we, e_dw, e_da, e_mem);
    #1;
    last_we = we_dmem;
    check("we_dmem", {28'h0, we_dmem}, {28'h0, e_we});
    if (e_mem) check("daddr", daddr, e_da);
    if (e_we != 4'b0000) check("dwdata", dwdata, e_dw);
    @(posedge clk);
    #1;
    check("pc", PC, ref_pc);
    check("x31", x31, ref_x[31]);
  endtask

  task automatic exec(input kind_t k, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm);
    @(negedge clk);
    exec_now(k, rd, rs1, rs2, imm);
  endtask

  task automatic release_reset(input kind_t k, input int rd, input int rs1, input int rs2,
                               input logic [31:0] imm);
    @(negedge clk);
    reset = 1'b1;
    exec_now(k, rd, rs1, rs2, imm);
  endtask

  // Reset lands between clock edges and must take effect without waiting for one.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    idata = enc(K_SW, 0, 0, 31, 32'h0);
    #1;
    model_reset();
    check("async_rst_pc", PC, 32'h0);
    check("async_rst_x31", x31, 32'h0);
    check("async_rst_we", {28'h0, we_dmem}, 32'h0);
    #20;
  endtask

  function automatic int pick_reg();
    int v;
    v = $urandom_range(0, 8);
    return (v == 8) ? 31 : v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_we  = 4'h0;
    for (int i = 0; i < 64; i++) dut_mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    model_reset();

    // Reset held for 100 ns with a store word on the bus.
    reset = 1'b1;
    idata = enc(K_SW, 0, 0, 2, 32'h0);
    #2;
    reset = 1'b0;
    #100;
    check("rst_pc", PC, 32'h0);
    check("rst_x31", x31, 32'h0);
    check("rst_we", {28'h0, we_dmem}, 32'h0);

    // NOP stream after release.
    release_reset(K_ADDI, 0, 0, 0, 32'h0);
    check("nop_pc4", PC, 32'd4);
    exec(K_ADDI, 0, 0, 0, 32'h0);
    check("nop_pc8", PC, 32'd8);

    // Arithmetic chain.
    exec(K_ADDI, 31, 0, 0, 32'd5);
    check("addi_x31", x31, 32'd5);
    exec(K_ADDI, 1, 0, 0, 32'hFFFFFFFD);
    exec(K_ADD, 31, 31, 1, 32'h0);
    check("add_neg", x31, 32'd2);
    exec(K_SUB, 31, 0, 31, 32'h0);
    check("sub_wrap", x31, 32'hFFFFFFFE);
    exec(K_SRAI, 31, 31, 0, 32'd1);
    check("srai_sign", x31, 32'hFFFFFFFF);

    // Stores and loads with lane placement.
    exec(K_LUI, 2, 0, 0, 32'h12345000);
    exec(K_ADDI, 2, 2, 0, 32'h678);
    exec(K_SW, 0, 0, 2, 32'd0);
    check("sw_we", {28'h0, last_we}, 32'hF);
    exec(K_SB, 0, 0, 2, 32'd5);
    check("sb_we", {28'h0, last_we}, 32'h2);
    exec(K_LW, 31, 0, 0, 32'd4);
    check("lw_after_sb", x31, 32'h00007800);
    exec(K_LB, 31, 0, 0, 32'd3);
    check("lb_byte3", x31, 32'h00000012);

    // Sign/zero extension of sub-word loads.
    exec(K_ADDI, 3, 0, 0, 32'h0F0);
    exec(K_SB, 0, 0, 3, 32'd8);
    exec(K_LUI, 3, 0, 0, 32'h00008000);
    exec(K_ADDI, 3, 3, 0, 32'd1);
    exec(K_SH, 0, 0, 3, 32'd10);
    check("sh_we", {28'h0, last_we}, 32'hC);
    exec(K_LB, 31, 0, 0, 32'd8);
    check("lb_sext", x31, 32'hFFFFFFF0);
    exec(K_LBU, 31, 0, 0, 32'd8);
    check("lbu_zext", x31, 32'h000000F0);
    exec(K_LH, 31, 0, 0, 32'd10);
    check("lh_sext", x31, 32'hFFFF8001);
    exec(K_LHU, 31, 0, 0, 32'd10);
    check("lhu_zext", x31, 32'h00008001);

    // Mid-program asynchronous reset, then control flow from PC 0.
    async_reset();
    release_reset(K_ADDI, 1, 0, 0, 32'hFFFFFFFF);
    exec(K_ADDI, 2, 0, 0, 32'd1);
    exec(K_BLT, 0, 1, 2, 32'd8);
    check("blt_taken", PC, 32'd16);
    exec(K_JAL, 31, 0, 0, 32'd12);
    check("jal_pc", PC, 32'd28);
    check("jal_link", x31, 32'd20);
    exec(K_JALR, 0, 31, 0, 32'd1);
    check("jalr_pc", PC, 32'd20);
    exec(K_BLTU, 0, 1, 2, 32'd8);
    check("bltu_not_taken", PC, 32'd24);

    // x0 stays zero; unrecognised words retire as NOPs.
    exec(K_ADDI, 0, 0, 0, 32'd7);
    exec(K_ADD, 31, 0, 0, 32'h0);
    check("x0_zero", x31, 32'h0);
    exec(K_ADDI, 31, 0, 0, 32'd9);
    exec(K_RAW, 0, 0, 0, 32'h00000000);
    check("zero_word_x31", x31, 32'd9);
    check("zero_word_pc", PC, 32'd40);
    exec(K_RAW, 0, 0, 0, 32'h0000000F);
    exec(K_RAW, 0, 0, 0, 32'h00000073);
    exec(K_RAW, 0, 0, 0, 32'h00100073);

    // Random instruction stream.
    for (int n = 0; n < 500; n++) begin
      int          sel;
      int          rd;
      int          rs1;
      int          rs2;
      kind_t       k;
      logic [31:0] imm;
      logic [31:0] w;
      sel = $urandom_range(0, 99);
      rd  = pick_reg();
      rs1 = pick_reg();
      rs2 = pick_reg();
      imm = 32'($signed(12'($urandom_range(0, 4095))));
      if (sel < 30) begin
        k = kind_t'(int'(K_ADDI) + int'($urandom_range(0, 8)));
        if (k inside {[K_SLLI:K_SRAI]}) imm = 32'($urandom_range(0, 31));
      end else if (sel < 55) begin
        k = kind_t'(int'(K_ADD) + int'($urandom_range(0, 9)));
      end else if (sel < 63) begin
        k   = ($urandom_range(0, 1) == 1) ? K_LUI : K_AUIPC;
        imm = $urandom() & 32'hFFFFF000;
      end else if (sel < 73) begin
        k   = kind_t'(int'(K_LB) + int'($urandom_range(0, 4)));
        rs1 = 0;
        imm = 32'($urandom_range(0, 255));
      end else if (sel < 81) begin
        k   = kind_t'(int'(K_SB) + int'($urandom_range(0, 2)));
        rs1 = 0;
        imm = 32'($urandom_range(0, 255));
      end else if (sel < 89) begin
        k   = kind_t'(int'(K_BEQ) + int'($urandom_range(0, 5)));
        imm = 32'((int'($urandom_range(0, 32)) - 16) * 4);
      end else if (sel < 93) begin
        k   = K_JAL;
        imm = 32'((int'($urandom_range(0, 512)) - 256) * 4);
      end else if (sel < 96) begin
        k = K_JALR;
      end else begin
        k = K_RAW;
        w = $urandom();
        case ($urandom_range(0, 3))
          0:       w = 32'h0;
          1:       w[6:0] = 7'b0001111;
          2:       w[6:0] = 7'b1110011;
          default: w[6:0] = 7'b1111111;
        endcase
        imm = w;
      end
      exec(k, rd, rs1, rs2, imm);
      if ($urandom_range(0, 2) == 0) exec(K_ADD, 31, pick_reg(), 0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
